// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encodings and NOP/bubble constants for the stall controller
package pipe_pkg;
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
  localparam int NOP_INSTR   = 0;
  localparam int CTRL_BUBBLE = 0;
endpackage

// File: rtl/pipe_stall_ctrl_stall_counter.sv
// stall_counter: saturating consecutive-stall counter with a sticky livelock watchdog
module stall_counter #(
  parameter int STALL_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  output logic [3:0] stall_cnt,
  output logic       stall_wdog
);
  logic [3:0] cnt_q, cnt_d;
  logic       wdog_q, wdog_d;
  // count stall cycles up to 15, clear on any non-stall cycle; watchdog latches off the registered count
  always_comb begin
    cnt_d  = stall ? ((cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1) : 4'd0;
    wdog_d = wdog_q | (32'(cnt_q) == STALL_MAX);
  end
  // counter and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      wdog_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wdog_q <= wdog_d;
    end
  end
  assign stall_cnt  = cnt_q;
  assign stall_wdog = wdog_q;
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: PC, IF/ID and ID/EX control owner reacting to hazard-unit stalls and taken branches.
// Optional STALL_STATS_EN adds free-running stall_total / flush_total counters.
module pipe_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              INSTR_W   = 32,
  parameter int              CTRL_W    = 9,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              STALL_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_write,
  input  logic               if_id_write,
  input  logic               control_dst,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [CTRL_W-1:0]  id_ex_ctrl,
  output logic [1:0]         state,
  output logic [3:0]         stall_cnt,
  output logic               stall_wdog
`ifdef STALL_STATS_EN
  ,
  output logic [31:0]        stall_total,
  output logic [31:0]        flush_total
`endif
);
  logic               stall, br;
  logic [PC_W-1:0]    pc_q, pc_d, pc4_q, pc4_d, pc_plus4;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  state_e             state_q, state_d;
  assign stall    = ~control_dst;
  assign br       = branch_taken & control_dst;
  assign pc_plus4 = pc_q + PC_W'(4);
  // datapath next-state: branch flush beats the per-register write enables
  always_comb begin
    pc_d    = br ? branch_target : pc_write ? pc_plus4 : pc_q;
    pc4_d   = br ? '0 : if_id_write ? pc_plus4 : pc4_q;
    instr_d = br ? INSTR_W'(NOP_INSTR) : if_id_write ? imem_instr : instr_q;
    ctrl_d  = control_dst ? ctrl_in : CTRL_W'(CTRL_BUBBLE);
  end
  // FSM next state is a pure function of this cycle's hazard inputs, whatever the current state
  always_comb begin
    state_d = stall ? ST_STALL : br ? ST_FLUSH : ST_RUN;
  end
  // pipeline registers and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      pc4_q   <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
      ctrl_q  <= CTRL_W'(CTRL_BUBBLE);
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      state_q <= state_d;
    end
  end
  stall_counter #(.STALL_MAX(STALL_MAX)) u_stall_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .stall_cnt (stall_cnt),
    .stall_wdog(stall_wdog)
  );
`ifdef STALL_STATS_EN
  logic [31:0] stall_total_q, flush_total_q;
  // wrapping event counters for stall and taken-branch cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_total_q <= '0;
      flush_total_q <= '0;
    end else begin
      stall_total_q <= stall_total_q + 32'(stall);
      flush_total_q <= flush_total_q + 32'(br);
    end
  end
  assign stall_total = stall_total_q;
  assign flush_total = flush_total_q;
`endif
  assign pc          = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign id_ex_ctrl  = ctrl_q;
  assign state       = state_q;
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed-vector self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_write = 1'b1, if_id_write = 1'b1, control_dst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_instr = 32'h8C220004;
  logic [8:0]  ctrl_in = 9'h1A5;
  logic [31:0] pc, if_id_pc4, if_id_instr;
  logic [8:0]  id_ex_ctrl;
  logic [1:0]  state;
  logic [3:0]  stall_cnt;
  logic        stall_wdog;
  int          n_checks = 0, n_fail = 0;
`ifdef STALL_STATS_EN
  logic [31:0] stall_total, flush_total, stall_base, flush_base;
`endif
  pipe_stall_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .control_dst  (control_dst),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_instr   (imem_instr),
    .ctrl_in      (ctrl_in),
    .pc           (pc),
    .if_id_pc4    (if_id_pc4),
    .if_id_instr  (if_id_instr),
    .id_ex_ctrl   (id_ex_ctrl),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .stall_wdog   (stall_wdog)
`ifdef STALL_STATS_EN
    ,
    .stall_total  (stall_total),
    .flush_total  (flush_total)
`endif
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_en(input logic v);
    pc_write    = v;
    if_id_write = v;
    control_dst = v;
  endtask
  initial begin
    step(1);
    rst_n = 1'b1;
    step(16);
    check("run_to_0x40", pc, 32'h40);
    rst_n = 1'b0;
    #1;
    check("rst_pc", pc, 32'h0);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4", if_id_pc4, 32'h0);
    check("rst_ctrl", id_ex_ctrl, 9'h0);
    check("rst_state", state, 2'd0);
    check("rst_cnt", stall_cnt, 4'd0);
    check("rst_wdog", stall_wdog, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(3);
    check("run_pc", pc, 32'hC);
    check("run_pc4", if_id_pc4, 32'hC);
    check("run_instr", if_id_instr, 32'h8C220004);
    check("run_ctrl", id_ex_ctrl, 9'h1A5);
    check("run_state", state, 2'd0);
    set_en(1'b0);
    step(1);
    check("stall_pc", pc, 32'hC);
    check("stall_pc4", if_id_pc4, 32'hC);
    check("stall_ctrl", id_ex_ctrl, 9'h0);
    check("stall_state", state, 2'd1);
    check("stall_cnt1", stall_cnt, 4'd1);
    set_en(1'b1);
    step(1);
    check("rel_pc", pc, 32'h10);
    check("rel_ctrl", id_ex_ctrl, 9'h1A5);
    check("rel_state", state, 2'd0);
    check("rel_cnt", stall_cnt, 4'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    step(1);
    check("br_pc", pc, 32'h100);
    check("br_instr", if_id_instr, 32'h0);
    check("br_pc4", if_id_pc4, 32'h0);
    check("br_state", state, 2'd2);
    branch_taken = 1'b0;
    step(1);
    check("br_after_pc", pc, 32'h104);
    check("br_after_pc4", if_id_pc4, 32'h104);
    check("br_after_state", state, 2'd0);
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    set_en(1'b0);
    step(1);
    check("brst_pc", pc, 32'h104);
    check("brst_instr", if_id_instr, 32'h8C220004);
    check("brst_state", state, 2'd1);
    set_en(1'b1);
    step(1);
    check("brrel_pc", pc, 32'h200);
    check("brrel_instr", if_id_instr, 32'h0);
    check("brrel_state", state, 2'd2);
    branch_taken = 1'b0;
    if_id_write  = 1'b0;
    step(1);
    check("split_pc", pc, 32'h204);
    check("split_instr", if_id_instr, 32'h0);
    check("split_state", state, 2'd0);
`ifdef STALL_STATS_EN
    stall_base = stall_total;
    flush_base = flush_total;
    check("flush_total", flush_base, 32'd2);
`endif
    set_en(1'b0);
    step(14);
    check("ll_cnt14", stall_cnt, 4'd14);
    check("ll_wdog14", stall_wdog, 1'b0);
    step(1);
    check("ll_cnt15", stall_cnt, 4'd15);
    step(1);
    check("ll_wdog16", stall_wdog, 1'b1);
    check("ll_cnt16", stall_cnt, 4'd15);
    step(4);
    check("ll_cnt20", stall_cnt, 4'd15);
    check("ll_wdog20", stall_wdog, 1'b1);
    check("ll_pc", pc, 32'h204);
`ifdef STALL_STATS_EN
    check("stall_total", stall_total - stall_base, 32'd20);
`endif
    set_en(1'b1);
    step(1);
    check("ll_rel_cnt", stall_cnt, 4'd0);
    check("ll_rel_wdog", stall_wdog, 1'b1);
    check("ll_rel_state", state, 2'd0);
    rst_n = 1'b0;
    #1;
    check("rst2_wdog", stall_wdog, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
